backscatter_phase_mod: RTL and testbench

BACKSCATTER_PHASE_MOD -- requirements
Module: backscatter_phase_mod

---
 rtl/backscatter_pkg.sv | 25 ++
 rtl/sym_fifo.sv | 45 ++++
 rtl/backscatter_phase_mod.sv | 162 ++++++++++++++++
 tb/tb_backscatter_phase_mod.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/backscatter_pkg.sv
// Shared types and helpers for the backscatter phase modulator: FSM states,
// default parameter values and the quadrant/phase adder.
package backscatter_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_SYM_W = 2;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A 2-phase symbol is a half-period shift, so it moves the quadrant by two.
  function automatic logic [1:0] quad_add(input logic [1:0] quadrant,
                                          input logic [1:0] phase,
                                          input int         sym_w);
    logic [1:0] offset;
    offset = (sym_w == 2) ? phase : {phase[0], 1'b0};
    return quadrant + offset;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// Show-ahead symbol FIFO; pop_data is the head entry whenever empty is low.
module sym_fifo #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [SYM_W-1:0] push_data,
  input  logic             pop,
  output logic [SYM_W-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer bit separates full from empty when the indices match.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/backscatter_phase_mod.sv
// Phase-shift keyed backscatter modulator: a free-running quadrature carrier
// whose switch copy is rotated by queued symbols during a triggered burst.
module backscatter_phase_mod
  import backscatter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int SYM_W = DEF_SYM_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger_signal,
  input  logic [CNT_W-1:0] quarter_cycles,
  input  logic [CNT_W-1:0] symbol_cycles,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym_data,
  output logic             sym_ready,
  output logic             carrier_out,
  output logic             signal_into_switch,
  output logic             tx_active,
  output logic             done,
  output logic             underrun,
  output state_t           state_dbg
);

  state_t           state;
  logic [CNT_W-1:0] q_eff;
  logic [CNT_W-1:0] s_eff;
  logic [CNT_W-1:0] q_cnt;
  logic [CNT_W-1:0] sym_timer;
  logic [1:0]       quadrant;
  logic [1:0]       eff_quadrant;
  logic [1:0]       phase_ext;
  logic [SYM_W-1:0] phase;
  logic [SYM_W-1:0] fifo_head;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] sym_cnt;
  logic             trig_prev;
  logic             trig_edge;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             start_ok;
  logic             timer_exp;
  logic             last_sym;
  logic             next_pop;

  assign q_eff = (quarter_cycles == '0) ? CNT_W'(1) : quarter_cycles;
  assign s_eff = (symbol_cycles == '0) ? CNT_W'(1) : symbol_cycles;

  assign sym_ready = ~fifo_full;
  assign state_dbg = state;

  sym_fifo #(
    .SYM_W (SYM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (sym_valid),
    .push_data (sym_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Carrier timebase. The >= compare keeps the counter sane if quarter_cycles
  // shrinks below the current count while running.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_cnt    <= '0;
      quadrant <= '0;
    end else if (q_cnt >= q_eff - 1'b1) begin
      q_cnt    <= '0;
      quadrant <= quadrant + 2'd1;
    end else begin
      q_cnt <= q_cnt + 1'b1;
    end
  end

  assign phase_ext    = 2'(phase);
  assign eff_quadrant = quad_add(quadrant, phase_ext, SYM_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      carrier_out        <= 1'b0;
      signal_into_switch <= 1'b0;
    end else begin
      carrier_out        <= quadrant[1];
      signal_into_switch <= tx_active & eff_quadrant[1];
    end
  end

  assign trig_edge = trigger_signal & ~trig_prev;
  assign start_ok  = (state == ST_IDLE) && trig_edge && (tx_len != '0) && !fifo_empty;
  assign timer_exp = (state == ST_SEND) && (sym_timer <= CNT_W'(1));
  assign last_sym  = ((sym_cnt + 1'b1) == len_r);
  assign next_pop  = timer_exp && !last_sym && !fifo_empty;
  assign fifo_pop  = start_ok | next_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      sym_timer <= '0;
      sym_cnt   <= '0;
      len_r     <= '0;
      phase     <= '0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      // A trigger already high when reset drops must not count as an edge.
      trig_prev <= 1'b1;
    end else begin
      trig_prev <= trigger_signal;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            phase     <= fifo_head;
            sym_timer <= s_eff;
            sym_cnt   <= '0;
            len_r     <= tx_len;
            underrun  <= 1'b0;
            tx_active <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (timer_exp) begin
            sym_cnt <= sym_cnt + 1'b1;
            if (last_sym) begin
              tx_active <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else if (fifo_empty) begin
              underrun  <= 1'b1;
              tx_active <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end else begin
              phase     <= fifo_head;
              sym_timer <= s_eff;
            end
          end else begin
            sym_timer <= sym_timer - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          tx_active <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_backscatter_phase_mod.sv
// Bench for backscatter_phase_mod: directed bursts with expected results
// queued at stimulus time and checked by a per-cycle monitor.
module tb_backscatter_phase_mod;
  import backscatter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trigger_signal = 1'b0;
  logic [7:0]  quarter_cycles = 8'd4;
  logic [7:0]  symbol_cycles = 8'd32;
  logic [15:0] tx_len = 16'd0;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_data = 2'd0;
  logic        sym_ready, carrier_out, signal_into_switch, tx_active, done, underrun;
  state_t      state_dbg;

  logic        trig2 = 1'b0;
  logic [15:0] tx_len2 = 16'd0;
  logic        sym_valid2 = 1'b0;
  logic [0:0]  sym_data2 = 1'b0;
  logic        ready2, car2, sw2, act2, done2, und2;
  state_t      state_dbg2;

  always #5 clock = ~clock;

  backscatter_phase_mod #(.CNT_W(8), .SYM_W(2), .DEPTH(16), .LEN_W(16)) dut (
    .clock(clock), .reset(reset), .trigger_signal(trigger_signal),
    .quarter_cycles(quarter_cycles), .symbol_cycles(symbol_cycles), .tx_len(tx_len),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .carrier_out(carrier_out), .signal_into_switch(signal_into_switch),
    .tx_active(tx_active), .done(done), .underrun(underrun), .state_dbg(state_dbg)
  );

  backscatter_phase_mod #(.CNT_W(8), .SYM_W(1), .DEPTH(16), .LEN_W(16)) dut2 (
    .clock(clock), .reset(reset), .trigger_signal(trig2),
    .quarter_cycles(quarter_cycles), .symbol_cycles(symbol_cycles), .tx_len(tx_len2),
    .sym_valid(sym_valid2), .sym_data(sym_data2), .sym_ready(ready2),
    .carrier_out(car2), .signal_into_switch(sw2),
    .tx_active(act2), .done(done2), .underrun(und2), .state_dbg(state_dbg2)
  );

  typedef struct packed {
    logic        abort;
    logic        underrun;
    logic [15:0] active;
  } burst_exp_t;

  burst_exp_t exp_q[$];
  logic [1:0] phase_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int sc_val = 32;
  int q_val = 4;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // ---------------- monitor ----------------
  logic       hist [32];
  int         cyc = 0;
  bit         in_burst = 0;
  bit         done_tail = 0;
  logic       prev_active = 1'b0;
  burst_exp_t cur;
  int         s, act_cnt, mism, sym_k;
  logic [1:0] cur_p;

  always @(negedge clock) begin : mon
    int   lag;
    logic exp_sw;
    if (reset) begin
      if (in_burst) begin
        if (cur.abort) check("abort_mid_burst_active", tx_active, 1);
        else check("unexpected_reset_abort", 1, 0);
        in_burst = 0;
      end
    end else if (in_burst) begin
      s++;
      if (prev_active) begin
        if ((s - 1) % sc_val == 0) begin
          if (phase_q.size() > 0) cur_p = phase_q.pop_front();
          else cur_p = 2'd0;
          sym_k++;
          mism = 0;
        end
        // Phase p advances the switch by p quarter periods of the carrier.
        lag = ((4 - int'(cur_p)) % 4) * q_val;
        exp_sw = (lag == 0) ? carrier_out : hist[(cyc - lag) & 31];
        if (signal_into_switch !== exp_sw) mism++;
        if (s % sc_val == 0) check($sformatf("switch_sym%0d", sym_k), mism, 0);
      end
      if (tx_active) act_cnt++;
      if (done) begin
        check("done_tx_active_low", tx_active, 0);
        check("burst_active_cycles", act_cnt, 32'(cur.active));
        check("burst_underrun", underrun, 32'(cur.underrun));
        in_burst = 0;
        done_tail = 1;
      end else if (s > 5000) begin
        check("burst_timeout", 0, 1);
        in_burst = 0;
      end
    end else begin
      if (done_tail) begin
        check("done_width", done, 0);
        done_tail = 0;
      end else if (done === 1'b1) begin
        check("done_unexpected", done, 0);
      end
      if (tx_active === 1'b1 && prev_active !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("burst_unexpected", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          in_burst = 1;
          s = 0;
          act_cnt = 1;
          mism = 0;
          sym_k = -1;
        end
      end
    end
    prev_active = tx_active;
    hist[cyc & 31] = carrier_out;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [1:0] d);
    @(posedge clock); #1;
    sym_valid = 1'b1;
    sym_data  = d;
    @(posedge clock); #1;
    sym_valid = 1'b0;
  endtask

  task automatic push2(input logic d);
    @(posedge clock); #1;
    sym_valid2 = 1'b1;
    sym_data2  = d;
    @(posedge clock); #1;
    sym_valid2 = 1'b0;
  endtask

  task automatic pulse_trig();
    @(posedge clock); #1 trigger_signal = 1'b1;
    @(posedge clock); #1 trigger_signal = 1'b0;
  endtask

  task automatic pulse_trig2();
    @(posedge clock); #1 trig2 = 1'b1;
    @(posedge clock); #1 trig2 = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic expect_burst(input logic ab, input logic und, input int active);
    burst_exp_t e;
    e.abort    = ab;
    e.underrun = und;
    e.active   = 16'(active);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, done, 1);
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_carrier"}, carrier_out, 0);
    check({tag, "_switch"}, signal_into_switch, 0);
    check({tag, "_tx_active"}, tx_active, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_sym_ready"}, sym_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int   cnt_hi, cnt_sw, n_rise, rise_a, rise_b, nd, mism0, mism1;
    logic prev_c;

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");

    // Idle carrier: period 16, 50% duty, switch quiet.
    cnt_hi = 0; cnt_sw = 0; n_rise = 0; rise_a = 0; rise_b = 0;
    prev_c = carrier_out;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (carrier_out) cnt_hi++;
      if (signal_into_switch) cnt_sw++;
      if (carrier_out && !prev_c) begin
        if (n_rise == 0) rise_a = i;
        else if (n_rise == 1) rise_b = i;
        n_rise++;
      end
      prev_c = carrier_out;
    end
    check("idle_duty", cnt_hi, 32);
    check("idle_period", rise_b - rise_a, 16);
    check("idle_switch", cnt_sw, 0);

    // 2-phase instance: symbol 1 inverts the carrier, symbol 0 is in phase.
    push2(1'b1);
    push2(1'b0);
    tx_len2 = 16'd2;
    pulse_trig2();
    mism0 = 0; mism1 = 0;
    for (int k = 0; k <= 64; k++) begin
      @(negedge clock);
      if (k == 0) check("w1_active_start", act2, 1);
      if (k >= 1) begin
        if ((k - 1) / 32 == 0) begin
          if (sw2 !== ~car2) mism0++;
        end else if (sw2 !== car2) begin
          mism1++;
        end
      end
      if (k == 64) check("w1_done", done2, 1);
    end
    check("w1_sym0_inverted", mism0, 0);
    check("w1_sym1_inphase", mism1, 0);

    // Triggers ignored with an empty FIFO, then with tx_len == 0.
    tx_len = 16'd4;
    pulse_trig();
    repeat (4) @(negedge clock);
    check("trig_empty_ignored", tx_active, 0);
    push(2'd0);
    tx_len = 16'd0;
    pulse_trig();
    repeat (4) @(negedge clock);
    check("trig_len0_ignored", tx_active, 0);

    // Four-phase burst 0,1,2,3 with a stray trigger mid-burst.
    push(2'd1); push(2'd2); push(2'd3);
    tx_len = 16'd4;
    expect_burst(1'b0, 1'b0, 128);
    phase_q.push_back(2'd0); phase_q.push_back(2'd1);
    phase_q.push_back(2'd2); phase_q.push_back(2'd3);
    pulse_trig();
    repeat (50) @(negedge clock);
    pulse_trig();
    wait_done("burst4_done", 400);

    // Underrun: five symbols requested, three available.
    push(2'd0); push(2'd2); push(2'd1);
    tx_len = 16'd5;
    expect_burst(1'b0, 1'b1, 96);
    phase_q.push_back(2'd0); phase_q.push_back(2'd2); phase_q.push_back(2'd1);
    pulse_trig();
    wait_done("underrun_done", 400);
    check("underrun_sticky", underrun, 1);

    // Overflow: 17 pushes into a 16-deep FIFO.
    symbol_cycles = 8'd8;
    sc_val = 8;
    for (int i = 0; i < 17; i++) begin
      push(2'(i % 4));
      if (i == 14) check("ready_after15", sym_ready, 1);
      if (i == 15) check("ready_after16", sym_ready, 0);
      if (i == 16) check("ready_after17", sym_ready, 0);
    end
    tx_len = 16'd17;
    expect_burst(1'b0, 1'b1, 128);
    for (int i = 0; i < 16; i++) phase_q.push_back(2'(i % 4));
    pulse_trig();
    repeat (4) @(negedge clock);
    check("underrun_cleared_by_trigger", underrun, 0);
    wait_done("overflow_done", 400);
    check("ready_after_drain", sym_ready, 1);

    // Reset during the second symbol.
    symbol_cycles = 8'd32;
    sc_val = 32;
    push(2'd3); push(2'd1);
    tx_len = 16'd2;
    expect_burst(1'b1, 1'b0, 0);
    phase_q.push_back(2'd3); phase_q.push_back(2'd1);
    pulse_trig();
    repeat (40) @(negedge clock);
    pulse_reset();
    @(negedge clock);
    check_reset_outputs("midburst_reset");
    nd = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) nd++;
    end
    check("midburst_reset_no_done", nd, 0);
    pulse_trig();
    repeat (4) @(negedge clock);
    check("fifo_discarded", tx_active, 0);

    // Trigger held high through reset is not an edge.
    @(posedge clock); #1 trigger_signal = 1'b1;
    pulse_reset();
    push(2'd2);
    repeat (6) @(negedge clock);
    check("level_at_reset_not_edge", tx_active, 0);
    tx_len = 16'd1;
    expect_burst(1'b0, 1'b0, 32);
    phase_q.push_back(2'd2);
    @(posedge clock); #1 trigger_signal = 1'b0;
    pulse_trig();
    wait_done("single_done", 200);

    check("exp_q_drained", exp_q.size(), 0);
    check("phase_q_drained", phase_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
